apb_master: RTL

Single-outstanding APB initiator that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns the completion on a valid/ready response stream. It sits between the soft-core/bus-fabric side and the APB peripherals (GPIO, seven-segment, timers) and drives their shared pADDR/pWRITE/pWDATA and pSEL/pENABLE. It handles wait states, slave errors and a wait-state watchdog.

---
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_master.sv | 130 +++++++++++++
 2 files changed

// File: rtl/apb_master_if.sv
// Command/response stream and APB bus bundle for apb_master.
// The master modport is the initiator's view; slave is the fabric/peripheral side.
interface apb_master_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    localparam int unsigned CW = 1 + DW + AW;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] pADDR;
    logic          pSEL;
    logic          pENABLE;
    logic          pWRITE;
    logic [DW-1:0] pWDATA;
    logic [DW-1:0] pRDATA;
    logic          pREADY;
    logic          pSLVERR;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready, pRDATA, pREADY, pSLVERR,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        output pADDR, pSEL, pENABLE, pWRITE, pWDATA
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready, pRDATA, pREADY, pSLVERR,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        input  pADDR, pSEL, pENABLE, pWRITE, pWDATA
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: command stream in, SETUP/ACCESS on APB,
// completion (with slave error or watchdog abort) out on the response stream.
module apb_master #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic           pCLK,
    input logic           pRESET,
    apb_master_if.master  bus
);
    localparam int unsigned CW   = 1 + DW + AW;
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // Abort fires on the low-pREADY sample that would bring the count to TIMEOUT.
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    pwrite_d   = bus.cmd_data[CW-1];
                    pwdata_d   = bus.cmd_data[AW +: DW];
                    paddr_d    = bus.cmd_data[AW-1:0];
                    psel_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (bus.pREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = pwrite_q ? '0 : bus.pRDATA;
                    rsp_err_d     = bus.pSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (TIMEOUT != 0 && wait_cnt_q == CntLast) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else if (wait_cnt_q != CntMax) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pCLK or posedge pRESET) begin
        if (pRESET) begin
            state_q       <= StIdle;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Gated by pRESET so no command is taken while reset is asserted.
    assign bus.cmd_ready   = (state_q == StIdle) && !pRESET;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.pADDR       = paddr_q;
    assign bus.pSEL        = psel_q;
    assign bus.pENABLE     = penable_q;
    assign bus.pWRITE      = pwrite_q;
    assign bus.pWDATA      = pwdata_q;
endmodule
